// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller and the downstream character decoder.
// Game-state codes must stay bit-identical to the decoder's encoding.
package seg7_scan_ctrl_pkg;

    localparam int CHAR_NUM_W = 3;

    typedef enum logic [3:0] {
        READY    = 4'b0010,
        QUESTION = 4'b0011,
        INPUT    = 4'b0100,
        DRAW     = 4'b0110,
        WRONG    = 4'b0111,
        GOOD     = 4'b1000,
        OUCH     = 4'b1001,
        WIN      = 4'b1010,
        LOSE     = 4'b1011
    } game_state_t;

    typedef enum logic {
        PH_BLANK,
        PH_ON
    } slot_phase_t;

endpackage

// File: rtl/scan_tick_gen.sv
// Slot counter: wrap strobe and the phase the next counter value falls in; synchronous clear.
// Latency: wrap is combinational from cnt; no backpressure, en freezes the count.
module scan_tick_gen
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    output logic        wrap,
    output slot_phase_t phase_nxt
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        wrap    = en && !clr && (cnt == CNT_LAST);
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (en) begin
            cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
        end
        // Phase is looked up on the next count so the registered enables line up with it.
        phase_nxt = (cnt_nxt < CNT_BLANK) ? PH_BLANK : PH_ON;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Digit-scan controller: char_num index, active-low digit enables with blanking, blink and restart.
// Latency: all outputs registered one cycle; no backpressure, EN low freezes the scan and darkens.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int NDIG         = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 25
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  EN,
    input  logic [3:0]            STATE,
    input  logic                  BLINK_EN,
    output logic [CHAR_NUM_W-1:0] char_num,
    output logic [NDIG-1:0]       nDIG,
    output logic                  frame_tick
);

    localparam int FRM_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [CHAR_NUM_W-1:0] CHAR_LAST = CHAR_NUM_W'(NDIG - 1);
    localparam logic [FRM_W-1:0]      FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

    logic [3:0]            state_q;
    logic                  restart;
    logic                  wrap;
    slot_phase_t           phase_nxt;
    logic                  frame_wrap;
    logic [CHAR_NUM_W-1:0] char_nxt;
    logic [FRM_W-1:0]      frm_cnt;
    logic [FRM_W-1:0]      frm_nxt;
    logic                  blink_vis;
    logic                  vis_nxt;
    logic [NDIG-1:0]       ndig_nxt;
    logic                  tick_nxt;

    assign restart = (STATE != state_q);

    scan_tick_gen #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_tick (
        .clk       (CLK),
        .rst_n     (nRST),
        .en        (EN),
        .clr       (restart),
        .wrap      (wrap),
        .phase_nxt (phase_nxt)
    );

    always_comb begin
        frame_wrap = wrap && (char_num == CHAR_LAST);
        char_nxt   = char_num;
        frm_nxt    = frm_cnt;
        vis_nxt    = blink_vis;
        ndig_nxt   = '1;
        tick_nxt   = 1'b0;
        if (restart) begin
            char_nxt = '0;
            frm_nxt  = '0;
            vis_nxt  = 1'b1;
        end else if (EN) begin
            if (wrap) begin
                char_nxt = frame_wrap ? '0 : char_num + CHAR_NUM_W'(1);
            end
            tick_nxt = frame_wrap;
            if (!BLINK_EN) begin
                frm_nxt = '0;
                vis_nxt = 1'b1;
            end else if (frame_wrap) begin
                // The toggle lands on the frame boundary so a whole frame is lit or dark.
                if (frm_cnt == FRM_LAST) begin
                    frm_nxt = '0;
                    vis_nxt = ~blink_vis;
                end else begin
                    frm_nxt = frm_cnt + FRM_W'(1);
                end
            end
            if (phase_nxt == PH_ON && vis_nxt) begin
                for (int i = 0; i < NDIG; i++) begin
                    if (char_nxt == CHAR_NUM_W'(i)) ndig_nxt[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= 4'b0000;
            char_num   <= '0;
            frm_cnt    <= '0;
            blink_vis  <= 1'b1;
            nDIG       <= '1;
            frame_tick <= 1'b0;
        end else begin
            state_q    <= STATE;
            char_num   <= char_nxt;
            frm_cnt    <= frm_nxt;
            blink_vis  <= vis_nxt;
            nDIG       <= ndig_nxt;
            frame_tick <= tick_nxt;
        end
    end

endmodule
